epc_bus_master: RTL and testbench

- Initiator for the 32-bit EPC peripheral bus; drives address, data, byte enables and the active-low cs/wr/rd strobes, and waits on the responder's ready.
- Converts a simple valid/ready command interface from an internal controller or test sequencer into single EPC read/write transactions.
- Returns read data or a timeout error on a valid/ready response channel.
- Sits opposite the bus32 register-cell slaves, in the same clock domain.

---
 rtl/epc_bus_master_if.sv | 48 ++++
 rtl/epc_bus_master.sv | 113 +++++++++++
 tb/tb_epc_bus_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/epc_bus_master_if.sv
// Command, response and EPC bus signals of the EPC bus master, grouped so
// that the master and its environment connect with a single port.
interface epc_bus_master_if #(
    parameter int datawidth = 32,
    parameter int addrwidth = 8
);
    logic                 cmd_valid_in;
    logic                 cmd_ready_out;
    logic                 cmd_write_in;
    logic [addrwidth-1:0] cmd_addr_in;
    logic [datawidth-1:0] cmd_wdata_in;
    logic [3:0]           cmd_be_in;

    logic                 rsp_valid_out;
    logic                 rsp_ready_in;
    logic [datawidth-1:0] rsp_rdata_out;
    logic                 rsp_err_out;

    logic [31:0]          epc_addr_out;
    logic [31:0]          epc_data_out;
    logic                 epc_data_oe_out;
    logic [31:0]          epc_data_in;
    logic [3:0]           epc_be_out;
    logic                 epc_cs_n_out;
    logic                 epc_wr_n_out;
    logic                 epc_rd_n_out;
    logic                 epc_rdy_in;

    modport master (
        input  cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, cmd_be_in,
        output cmd_ready_out,
        output rsp_valid_out, rsp_rdata_out, rsp_err_out,
        input  rsp_ready_in,
        output epc_addr_out, epc_data_out, epc_data_oe_out, epc_be_out,
        output epc_cs_n_out, epc_wr_n_out, epc_rd_n_out,
        input  epc_data_in, epc_rdy_in
    );

    modport slave (
        output cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, cmd_be_in,
        input  cmd_ready_out,
        input  rsp_valid_out, rsp_rdata_out, rsp_err_out,
        output rsp_ready_in,
        input  epc_addr_out, epc_data_out, epc_data_oe_out, epc_be_out,
        input  epc_cs_n_out, epc_wr_n_out, epc_rd_n_out,
        output epc_data_in, epc_rdy_in
    );
endinterface

// File: rtl/epc_bus_master.sv
// EPC bus initiator: turns one valid/ready command into a single EPC read or
// write (setup, strobe with timeout, hold) and returns a valid/ready response.
module epc_bus_master #(
    parameter int datawidth      = 32,
    parameter int addrwidth      = 8,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clock_in,
    input  logic             reset_in,
    epc_bus_master_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } state_t;

    localparam logic [3:0]  SETUP_LAST   = 4'(SETUP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [3:0]  setup_cnt_reg;
    logic [15:0] timeout_cnt_reg;

    assign bus.cmd_ready_out = (state_reg == ST_IDLE);

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_reg           <= ST_IDLE;
            setup_cnt_reg       <= '0;
            timeout_cnt_reg     <= '0;
            bus.epc_addr_out    <= '0;
            bus.epc_data_out    <= '0;
            bus.epc_data_oe_out <= 1'b0;
            bus.epc_be_out      <= '0;
            bus.epc_cs_n_out    <= 1'b1;
            bus.epc_wr_n_out    <= 1'b1;
            bus.epc_rd_n_out    <= 1'b1;
            bus.rsp_valid_out   <= 1'b0;
            bus.rsp_rdata_out   <= '0;
            bus.rsp_err_out     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.cmd_valid_in) begin
                        bus.epc_addr_out    <= {{(32-addrwidth){1'b0}}, bus.cmd_addr_in};
                        bus.epc_data_out    <= bus.cmd_write_in ? bus.cmd_wdata_in : '0;
                        bus.epc_data_oe_out <= bus.cmd_write_in;
                        bus.epc_be_out      <= bus.cmd_be_in;
                        bus.epc_cs_n_out    <= 1'b0;
                        setup_cnt_reg       <= '0;
                        state_reg           <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    // The drive enable doubles as the latched write flag.
                    if (setup_cnt_reg == SETUP_LAST) begin
                        if (bus.epc_data_oe_out) begin
                            bus.epc_wr_n_out <= 1'b0;
                        end else begin
                            bus.epc_rd_n_out <= 1'b0;
                        end
                        state_reg <= ST_STROBE;
                    end else begin
                        setup_cnt_reg <= setup_cnt_reg + 4'd1;
                    end
                end

                ST_STROBE: begin
                    timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                    // Ready wins over timeout when both land on the same edge.
                    if (bus.epc_rdy_in) begin
                        bus.epc_wr_n_out  <= 1'b1;
                        bus.epc_rd_n_out  <= 1'b1;
                        bus.rsp_rdata_out <= bus.epc_data_oe_out ? '0 : bus.epc_data_in;
                        bus.rsp_err_out   <= 1'b0;
                        state_reg         <= ST_HOLD;
                    end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        bus.epc_wr_n_out  <= 1'b1;
                        bus.epc_rd_n_out  <= 1'b1;
                        bus.rsp_rdata_out <= '0;
                        bus.rsp_err_out   <= 1'b1;
                        state_reg         <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    bus.epc_cs_n_out    <= 1'b1;
                    bus.epc_data_oe_out <= 1'b0;
                    bus.epc_be_out      <= '0;
                    bus.rsp_valid_out   <= 1'b1;
                    timeout_cnt_reg     <= '0;
                    state_reg           <= ST_RESP;
                end

                ST_RESP: begin
                    if (bus.rsp_ready_in) begin
                        bus.rsp_valid_out <= 1'b0;
                        state_reg         <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_epc_bus_master.sv
// Directed bench for epc_bus_master: two instances (setup 1 and setup 3, both
// with an 8-cycle timeout) share stimulus; sel picks which one is observed.
module tb_epc_bus_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_be    = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] epc_din   = '0;
    logic        epc_rdy   = 1'b0;
    int          sel       = 0;

    logic [1:0]  cmd_ready_v, rsp_valid_v, rsp_err_v, oe_v, cs_n_v, wr_n_v, rd_n_v;
    logic [31:0] rdata_v [2];
    logic [31:0] addr_v  [2];
    logic [31:0] data_v  [2];
    logic [3:0]  be_v    [2];

    epc_bus_master_if bus_if [2] ();

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign bus_if[gi].cmd_valid_in = cmd_valid;
        assign bus_if[gi].cmd_write_in = cmd_write;
        assign bus_if[gi].cmd_addr_in  = cmd_addr;
        assign bus_if[gi].cmd_wdata_in = cmd_wdata;
        assign bus_if[gi].cmd_be_in    = cmd_be;
        assign bus_if[gi].rsp_ready_in = rsp_ready;
        assign bus_if[gi].epc_data_in  = epc_din;
        assign bus_if[gi].epc_rdy_in   = epc_rdy;

        assign cmd_ready_v[gi] = bus_if[gi].cmd_ready_out;
        assign rsp_valid_v[gi] = bus_if[gi].rsp_valid_out;
        assign rsp_err_v[gi]   = bus_if[gi].rsp_err_out;
        assign oe_v[gi]        = bus_if[gi].epc_data_oe_out;
        assign cs_n_v[gi]      = bus_if[gi].epc_cs_n_out;
        assign wr_n_v[gi]      = bus_if[gi].epc_wr_n_out;
        assign rd_n_v[gi]      = bus_if[gi].epc_rd_n_out;
        assign rdata_v[gi]     = bus_if[gi].rsp_rdata_out;
        assign addr_v[gi]      = bus_if[gi].epc_addr_out;
        assign data_v[gi]      = bus_if[gi].epc_data_out;
        assign be_v[gi]        = bus_if[gi].epc_be_out;

        epc_bus_master #(
            .datawidth      (32),
            .addrwidth      (8),
            .SETUP_CYCLES   ((gi == 0) ? 1 : 3),
            .TIMEOUT_CYCLES (8)
        ) dut (
            .clock_in (clk),
            .reset_in (rst),
            .bus      (bus_if[gi])
        );
    end

    logic        cmd_ready, rsp_valid, rsp_err, oe, cs_n, wr_n, rd_n;
    logic [31:0] rdata, addr, data;
    logic [3:0]  be;
    assign cmd_ready = cmd_ready_v[sel];
    assign rsp_valid = rsp_valid_v[sel];
    assign rsp_err   = rsp_err_v[sel];
    assign oe        = oe_v[sel];
    assign cs_n      = cs_n_v[sel];
    assign wr_n      = wr_n_v[sel];
    assign rd_n      = rd_n_v[sel];
    assign rdata     = rdata_v[sel];
    assign addr      = addr_v[sel];
    assign data      = data_v[sel];
    assign be        = be_v[sel];

    int n_checks = 0;
    int n_fail   = 0;
    int lat, wr_lo, rd_lo, first_lo;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; epc_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic launch(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        expect_eq("accept_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_be = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Runs from just after the accept edge until rsp_valid is seen; the
    // responder raises rdy once the strobe has been low for wait_n cycles.
    task automatic run_to_rsp(input int wait_n, input logic hold_high);
        int lo;
        logic viol;
        lo = 0; lat = 0; wr_lo = 0; rd_lo = 0; first_lo = 0; viol = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (!wr_n || !rd_n) begin
                if (first_lo == 0) first_lo = i;
                if (!wr_n) wr_lo++;
                if (!rd_n) rd_lo++;
                lo++;
            end
            if ((!wr_n && !rd_n) || ((!wr_n || !rd_n) && cs_n)) viol = 1'b1;
            epc_rdy = hold_high ? 1'b1 : ((!wr_n || !rd_n) && lo > wait_n);
            tick();
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        epc_rdy = hold_high;
        expect_eq("rsp_seen", 32'(lat != 0), 32'd1);
        expect_eq("strobe_rules", 32'(viol), 32'd0);
    endtask

    task automatic ack();
        expect_eq("resp_busy", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        expect_eq("ack_valid", 32'(rsp_valid), 32'd0);
        expect_eq("ack_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state of the setup-1 instance.
        sel = 0;
        do_reset();
        expect_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        expect_eq("rst_cs_n", 32'(cs_n), 32'd1);
        expect_eq("rst_wr_n", 32'(wr_n), 32'd1);
        expect_eq("rst_rd_n", 32'(rd_n), 32'd1);
        expect_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        expect_eq("rst_err", 32'(rsp_err), 32'd0);
        expect_eq("rst_rdata", rdata, 32'd0);
        expect_eq("rst_addr", addr, 32'd0);
        expect_eq("rst_data", data, 32'd0);
        expect_eq("rst_be", 32'(be), 32'd0);
        expect_eq("rst_oe", 32'(oe), 32'd0);

        // Write, ready on the first strobe cycle.
        epc_din = 32'hDEADBEEF;
        launch(1'b1, 8'h10, 32'hCAFEF00D, 4'hF);
        expect_eq("wr_addr", addr, 32'h00000010);
        expect_eq("wr_data", data, 32'hCAFEF00D);
        expect_eq("wr_oe", 32'(oe), 32'd1);
        expect_eq("wr_be", 32'(be), 32'hF);
        expect_eq("wr_cs_n", 32'(cs_n), 32'd0);
        expect_eq("wr_setup_wr_n", 32'(wr_n), 32'd1);
        run_to_rsp(0, 1'b0);
        expect_eq("wr_latency", 32'(lat), 32'd3);
        expect_eq("wr_strobe_len", 32'(wr_lo), 32'd1);
        expect_eq("wr_rd_n_low", 32'(rd_lo), 32'd0);
        expect_eq("wr_first_strobe", 32'(first_lo), 32'd2);
        expect_eq("wr_rdata", rdata, 32'd0);
        expect_eq("wr_err", 32'(rsp_err), 32'd0);
        expect_eq("wr_end_cs_n", 32'(cs_n), 32'd1);
        expect_eq("wr_end_oe", 32'(oe), 32'd0);
        expect_eq("wr_end_be", 32'(be), 32'd0);
        $display("txn write addr=0x10 latency=%0d err=%0d", lat, rsp_err);
        ack();

        // Read with four wait cycles.
        epc_din = 32'h12345678;
        launch(1'b0, 8'h24, 32'hFFFFFFFF, 4'hF);
        expect_eq("rd_addr", addr, 32'h00000024);
        expect_eq("rd_data_out", data, 32'd0);
        expect_eq("rd_oe", 32'(oe), 32'd0);
        run_to_rsp(4, 1'b0);
        expect_eq("rd_latency", 32'(lat), 32'd7);
        expect_eq("rd_strobe_len", 32'(rd_lo), 32'd5);
        expect_eq("rd_wr_n_low", 32'(wr_lo), 32'd0);
        expect_eq("rd_rdata", rdata, 32'h12345678);
        expect_eq("rd_err", 32'(rsp_err), 32'd0);
        $display("txn read addr=0x24 latency=%0d rdata=0x%08h", lat, rdata);
        ack();

        // Timeout: responder never ready.
        launch(1'b0, 8'h28, 32'd0, 4'hF);
        run_to_rsp(1000, 1'b0);
        expect_eq("to_latency", 32'(lat), 32'd10);
        expect_eq("to_strobe_len", 32'(rd_lo), 32'd8);
        expect_eq("to_err", 32'(rsp_err), 32'd1);
        expect_eq("to_rdata", rdata, 32'd0);
        expect_eq("to_cs_n", 32'(cs_n), 32'd1);
        $display("txn read addr=0x28 timeout err=%0d latency=%0d", rsp_err, lat);
        ack();

        // Back-to-back with the response held off for five cycles.
        launch(1'b1, 8'h30, 32'hA5A55A5A, 4'h3);
        run_to_rsp(0, 1'b0);
        expect_eq("b2b_latency", 32'(lat), 32'd3);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h34; cmd_be = 4'hF;
        for (int k = 0; k < 5; k++) begin
            expect_eq("b2b_cmd_ready", 32'(cmd_ready), 32'd0);
            expect_eq("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
            expect_eq("b2b_rdata", rdata, 32'd0);
            expect_eq("b2b_err", 32'(rsp_err), 32'd0);
            expect_eq("b2b_cs_n", 32'(cs_n), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        expect_eq("b2b_ack_valid", 32'(rsp_valid), 32'd0);
        expect_eq("b2b_ack_cs_n", 32'(cs_n), 32'd1);
        $display("txn write addr=0x30 latency=%0d held 5 cycles", lat);
        launch(1'b0, 8'h34, 32'd0, 4'hF);
        expect_eq("b2b2_cs_n", 32'(cs_n), 32'd0);
        expect_eq("b2b2_addr", addr, 32'h00000034);
        run_to_rsp(0, 1'b0);
        expect_eq("b2b2_latency", 32'(lat), 32'd3);
        expect_eq("b2b2_rdata", rdata, 32'h12345678);
        $display("txn read addr=0x34 latency=%0d rdata=0x%08h", lat, rdata);
        ack();

        // Reset in the middle of a read strobe, then a normal write.
        launch(1'b0, 8'h40, 32'd0, 4'hF);
        tick();
        expect_eq("mid_rd_n", 32'(rd_n), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_eq("mid_cs_n", 32'(cs_n), 32'd1);
        expect_eq("mid_rd_n_rel", 32'(rd_n), 32'd1);
        expect_eq("mid_wr_n", 32'(wr_n), 32'd1);
        expect_eq("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        expect_eq("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        launch(1'b1, 8'h44, 32'h0BADF00D, 4'hF);
        expect_eq("post_addr", addr, 32'h00000044);
        expect_eq("post_data", data, 32'h0BADF00D);
        run_to_rsp(0, 1'b0);
        expect_eq("post_latency", 32'(lat), 32'd3);
        expect_eq("post_strobe_len", 32'(wr_lo), 32'd1);
        expect_eq("post_err", 32'(rsp_err), 32'd0);
        $display("txn write addr=0x44 after reset latency=%0d", lat);
        ack();

        // Setup-3 instance with ready held high throughout.
        sel = 1;
        do_reset();
        epc_rdy = 1'b1;
        launch(1'b0, 8'h48, 32'd0, 4'hF);
        run_to_rsp(0, 1'b1);
        expect_eq("s3_first_strobe", 32'(first_lo), 32'd4);
        expect_eq("s3_strobe_len", 32'(rd_lo), 32'd1);
        expect_eq("s3_latency", 32'(lat), 32'd5);
        expect_eq("s3_rdata", rdata, 32'h12345678);
        $display("txn read addr=0x48 setup3 latency=%0d", lat);
        ack();
        epc_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
